dmem_access: RTL

//  MEM-stage data access unit directly downstream of address translation.

---
 rtl/dmem_access_pkg.sv | 50 +++++
 rtl/dmem_format.sv | 52 +++++
 rtl/dmem_access.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_pkg.sv
// Shared pipeline types for the MEM-stage data access unit: word/size types,
// FSM state encoding, exception codes and the latched request record.
package dmem_access_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } dmem_state_t;

  typedef enum logic [1:0] {
    MSIZE_BYTE = 2'd0,
    MSIZE_HALF = 2'd1,
    MSIZE_WORD = 2'd2,
    MSIZE_RSVD = 2'd3
  } msize_t;

  typedef logic [4:0] exc_code_t;

  localparam exc_code_t EXC_NONE = 5'd0;
  localparam exc_code_t EXC_MOD  = 5'd1;
  localparam exc_code_t EXC_TLBL = 5'd2;
  localparam exc_code_t EXC_TLBS = 5'd3;
  localparam exc_code_t EXC_ADEL = 5'd4;
  localparam exc_code_t EXC_ADES = 5'd5;

  // Everything about one access that must stay stable while it is on the bus.
  typedef struct packed {
    word_t  addr;
    msize_t size;
    logic   is_unsigned;
    logic   is_store;
    logic   uncached;
    word_t  wdata;
  } req_t;

  // Bus address: low bits that the access size does not use are cleared.
  function automatic word_t align_addr(word_t a, msize_t s);
    case (s)
      MSIZE_BYTE: align_addr = a;
      MSIZE_HALF: align_addr = {a[31:1], 1'b0};
      default:    align_addr = {a[31:2], 2'b00};
    endcase
  endfunction

endpackage

// File: rtl/dmem_format.sv
// Combinational lane logic: store byte enables and lane-replicated store data,
// and lane selection plus sign/zero extension of the raw read word.
module dmem_format
  import dmem_access_pkg::*;
(
  input  msize_t     size_i,
  input  logic [1:0] addr_lo_i,
  input  logic       unsigned_i,
  input  word_t      wdata_i,
  input  word_t      rdata_raw_i,
  output logic [3:0] strobe_o,
  output word_t      wdata_o,
  output word_t      rdata_o
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    case (addr_lo_i)
      2'd0:    rd_byte = rdata_raw_i[7:0];
      2'd1:    rd_byte = rdata_raw_i[15:8];
      2'd2:    rd_byte = rdata_raw_i[23:16];
      default: rd_byte = rdata_raw_i[31:24];
    endcase
    rd_half = addr_lo_i[1] ? rdata_raw_i[31:16] : rdata_raw_i[15:0];
  end

  always_comb begin
    strobe_o = 4'hF;
    wdata_o  = wdata_i;
    rdata_o  = rdata_raw_i;
    case (size_i)
      MSIZE_BYTE: begin
        strobe_o = 4'b0001 << addr_lo_i;
        wdata_o  = {4{wdata_i[7:0]}};
        rdata_o  = unsigned_i ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      end
      MSIZE_HALF: begin
        strobe_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o  = {2{wdata_i[15:0]}};
        rdata_o  = unsigned_i ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      end
      default: begin
        strobe_o = 4'hF;
        wdata_o  = wdata_i;
        rdata_o  = rdata_raw_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access.sv
// MEM-stage data access unit: fault prioritisation, single-outstanding data-bus
// handshake, load formatting and stall. Define DMEM_ALIGN_CHECK_EN for AdEL/AdES.
//
// Bus handshake: a request is presented while dbus_valid=1 with address, size,
// strobe and data held constant until the cycle dbus_addr_ok=1 (the transfer
// cycle); its single response arrives on a later or the same cycle with
// dbus_data_ok=1. No new request is issued until that response has been seen.
module dmem_access
  import dmem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_vaddr,
  input  logic [31:0] req_paddr,
  input  logic        req_uncached,
  input  logic [31:0] req_wdata,
  input  logic        tlb_refill,
  input  logic        tlb_invalid,
  input  logic        tlb_modified,
  input  logic        flush,
  input  logic        mem_ready,
  output logic        dbus_valid,
  output logic [31:0] dbus_addr,
  output logic [1:0]  dbus_size,
  output logic [3:0]  dbus_strobe,
  output logic [31:0] dbus_wdata,
  output logic        dbus_uncached,
  input  logic        dbus_addr_ok,
  input  logic        dbus_data_ok,
  input  logic [31:0] dbus_rdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic        exc_refill,
  output logic [31:0] exc_badvaddr,
  output dmem_state_t dbg_state
);

  dmem_state_t state_q, state_d;
  req_t        req_q, req_d;
  word_t       rdata_q, rdata_d;

  logic        addr_err;
  logic        fault_any;
  exc_code_t   code_c;
  logic        refill_c;

  logic [3:0]  fmt_strobe;
  word_t       fmt_wdata;
  word_t       fmt_rdata;

  dmem_format u_format (
    .size_i      (req_q.size),
    .addr_lo_i   (req_q.addr[1:0]),
    .unsigned_i  (req_q.is_unsigned),
    .wdata_i     (req_q.wdata),
    .rdata_raw_i (dbus_rdata),
    .strobe_o    (fmt_strobe),
    .wdata_o     (fmt_wdata),
    .rdata_o     (fmt_rdata)
  );

  always_comb begin
    addr_err = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    case (msize_t'(req_size))
      MSIZE_BYTE: addr_err = 1'b0;
      MSIZE_HALF: addr_err = req_vaddr[0];
      default:    addr_err = |req_vaddr[1:0];
    endcase
`else
    addr_err = 1'b0;
`endif
  end

  // Highest-priority fault wins; a clean-page hit only matters for stores.
  always_comb begin
    code_c   = EXC_NONE;
    refill_c = 1'b0;
    if (addr_err) begin
      code_c = req_is_store ? EXC_ADES : EXC_ADEL;
    end else if (tlb_refill) begin
      code_c   = req_is_store ? EXC_TLBS : EXC_TLBL;
      refill_c = 1'b1;
    end else if (tlb_invalid) begin
      code_c = req_is_store ? EXC_TLBS : EXC_TLBL;
    end else if (req_is_store && tlb_modified) begin
      code_c = EXC_MOD;
    end
    fault_any = addr_err | tlb_refill | tlb_invalid | (req_is_store & tlb_modified);
  end

  always_comb begin
    exc_valid    = (state_q == IDLE) && req_valid && !flush && fault_any;
    exc_code     = exc_valid ? code_c : EXC_NONE;
    exc_refill   = exc_valid & refill_c;
    exc_badvaddr = exc_valid ? req_vaddr : '0;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush && !fault_any) begin
          state_d           = REQ;
          stall             = 1'b1;
          req_d.addr        = align_addr(req_paddr, msize_t'(req_size));
          req_d.size        = msize_t'(req_size);
          req_d.is_unsigned = req_unsigned;
          req_d.is_store    = req_is_store;
          req_d.uncached    = req_uncached;
          req_d.wdata       = req_wdata;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (flush) begin
          // Once accepted, the response still has to be consumed unless it is already here.
          if (!dbus_addr_ok || dbus_data_ok) state_d = IDLE;
          else                               state_d = DRAIN;
        end else if (dbus_addr_ok) begin
          if (dbus_data_ok) begin
            state_d = DONE;
            if (!req_q.is_store) rdata_d = fmt_rdata;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (dbus_data_ok) begin
          state_d = flush ? IDLE : DONE;
          if (!flush && !req_q.is_store) rdata_d = fmt_rdata;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (flush || mem_ready) state_d = IDLE;
      end
      DRAIN: begin
        if (dbus_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    dbus_valid    = (state_q == REQ);
    dbus_addr     = dbus_valid ? req_q.addr : '0;
    dbus_size     = dbus_valid ? req_q.size : 2'b00;
    dbus_strobe   = (dbus_valid && req_q.is_store) ? fmt_strobe : 4'b0000;
    dbus_wdata    = (dbus_valid && req_q.is_store) ? fmt_wdata : '0;
    dbus_uncached = dbus_valid & req_q.uncached;
    rdata         = rdata_q;
    dbg_state     = state_q;
  end

endmodule
